i2c_target: RTL and testbench

- I2C target (slave) for the 7-bit-address bus driven by the team's I2C master. Default address is 0x27, the same as the LCD backpack the master addresses.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Write transfers: ACKs its own address and delivers each received byte on a strobe interface. Read transfers: shifts out bytes supplied by the user logic.
- Sits at the pad boundary. SDA is open-drain inout; SCL is input only (no clock stretching).

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_pin_sync.sv | 73 +++++++
 rtl/i2c_target.sv | 187 ++++++++++++++++++
 tb/tb_i2c_target.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and FSM state type for the I2C target.
package i2c_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned BYTE_W = 8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic [ADDR_W-1:0] DEFAULT_LCD_ADDR = 7'h27;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_state_e;

endpackage

// File: rtl/i2c_pin_sync.sv
// Pin conditioner: synchronizer, optional stable-sample glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN) and rise/fall detection for one bus pin.
module i2c_pin_sync
   import i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   localparam bit FILTER_ON = 1'b1;
`else
   localparam bit FILTER_ON = 1'b0;
`endif

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   filt;
   logic                   prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      end
   end

   if (FILTER_ON) begin : g_filter
      logic       filt_q;
      logic [3:0] cnt_q;

      // Output follows the input only after FILT_LEN consecutive differing samples.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
         end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == 4'(FILT_LEN - 1)) begin
               filt_q <= sync_q[SYNC_STAGES-1];
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
         end else begin
            cnt_q <= '0;
         end
      end

      assign filt = filt_q;
   end else begin : g_bypass
      assign filt = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= filt;
      end
   end

   assign level_o = filt;
   assign rise_o  = filt & ~prev_q;
   assign fall_o  = ~filt & prev_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit I2C target with byte strobe interfaces; open-drain SDA, no clock stretching.
// Optional glitch filter on both pins via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] TARGET_ADDR = DEFAULT_LCD_ADDR,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter int unsigned       FILT_LEN    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCL,
   inout  logic              SDA,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_full,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_req,
   output logic              busy,
   output logic              rw_dir,
   output logic              nack_seen
);

   i2c_state_e        state_q;
   logic [BYTE_W-1:0] shift_q;
   logic [BYTE_W-1:0] rx_data_q;
   logic [2:0]        bitcnt_q;
   logic              byte_done_q;
   logic              sda_oe_q;
   logic              load_q;
   logic              rx_valid_q;
   logic              tx_req_q;
   logic              busy_q;
   logic              rw_q;
   logic              nack_q;

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_ev, stop_ev;

   i2c_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .pin_i  (SCL),
      .level_o(scl_lvl),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .pin_i  (SDA),
      .level_o(sda_lvl),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   assign start_ev = sda_fall & scl_lvl;
   assign stop_ev  = sda_rise & scl_lvl;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '1;
         bitcnt_q    <= '1;
         byte_done_q <= 1'b0;
         sda_oe_q    <= 1'b0;
         load_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= RW_WRITE;
         nack_q      <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         load_q     <= 1'b0;
         if (start_ev) begin
            state_q     <= ST_ADDR;
            bitcnt_q    <= '1;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            nack_q      <= 1'b0;
         end else if (stop_ev) begin
            state_q     <= ST_IDLE;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            // tx_data is taken one clk after the tx_req strobe
            if (load_q) begin
               shift_q  <= tx_data;
               sda_oe_q <= ~tx_data[BYTE_W-1];
            end
            case (state_q)
               ST_ADDR, ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift_q     <= {shift_q[BYTE_W-2:0], sda_lvl};
                     bitcnt_q    <= bitcnt_q - 3'd1;
                     byte_done_q <= (bitcnt_q == '0);
                  end else if (scl_fall && byte_done_q) begin
                     byte_done_q <= 1'b0;
                     bitcnt_q    <= '1;
                     if (state_q == ST_ADDR) begin
                        if (shift_q[BYTE_W-1:1] == TARGET_ADDR && shift_q[BYTE_W-1:1] != '0) begin
                           sda_oe_q <= 1'b1;
                           rw_q     <= shift_q[0];
                           busy_q   <= 1'b1;
                           state_q  <= ST_ADDR_ACK;
                        end else begin
                           state_q <= ST_IGNORE;
                        end
                     end else begin
                        if (!rx_full) begin
                           rx_data_q  <= shift_q;
                           rx_valid_q <= 1'b1;
                           sda_oe_q   <= 1'b1;
                        end else begin
                           sda_oe_q <= 1'b0;
                        end
                        state_q <= ST_WR_ACK;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     if (rw_q == RW_READ) begin
                        tx_req_q <= 1'b1;
                        load_q   <= 1'b1;
                        state_q  <= ST_RD_DATA;
                     end else begin
                        state_q <= ST_WR_DATA;
                     end
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= ST_WR_DATA;
                  end
               end
               ST_RD_DATA: begin
                  if (scl_rise) begin
                     bitcnt_q    <= bitcnt_q - 3'd1;
                     byte_done_q <= (bitcnt_q == '0);
                  end else if (scl_fall) begin
                     if (byte_done_q) begin
                        byte_done_q <= 1'b0;
                        sda_oe_q    <= 1'b0;
                        state_q     <= ST_RD_ACK;
                     end else begin
                        shift_q  <= {shift_q[BYTE_W-2:0], 1'b1};
                        sda_oe_q <= ~shift_q[BYTE_W-2];
                     end
                  end
               end
               ST_RD_ACK: begin
                  // NACK ends the read right at the sampling edge
                  if (scl_rise && sda_lvl) begin
                     nack_q  <= 1'b1;
                     state_q <= ST_IGNORE;
                  end else if (scl_fall) begin
                     tx_req_q <= 1'b1;
                     load_q   <= 1'b1;
                     bitcnt_q <= '1;
                     state_q  <= ST_RD_DATA;
                  end
               end
               ST_IDLE, ST_IGNORE: ;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign tx_req    = tx_req_q;
   assign busy      = busy_q;
   assign rw_dir    = rw_q;
   assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master bench for i2c_target with a transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_target;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic       rx_full = 1'b0;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, busy, rw_dir, nack_seen;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_target #(.TARGET_ADDR(7'h27), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .SCL      (scl),
      .SDA      (sda),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_full  (rx_full),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy),
      .rw_dir   (rw_dir),
      .nack_seen(nack_seen)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          errors = 0;
   int          q = 10;
   logic        glitch_arm = 1'b0;
   logic [7:0]  rx_log[$];
   logic [7:0]  tx_src[$];
   int unsigned txreq_cnt = 0;
   int unsigned dut_low_cnt = 0;

   // Bus/strobe monitor and tx_data responder
   initial forever begin
      @(negedge clk);
      if (rx_valid) rx_log.push_back(rx_data);
      if (tx_req) begin
         txreq_cnt++;
         tx_data = (tx_src.size() > 0) ? tx_src.pop_front() : 8'($urandom);
      end
      if (sda === 1'b0 && !m_low) dut_low_cnt++;
   end

   initial begin
      repeat (150000) @(posedge clk);
      errors++;
      $display("FAIL watchdog: run exceeded 150000 cycles, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   task automatic wq();
      repeat (q) @(negedge clk);
   endtask

   task automatic clear_mon();
      rx_log.delete();
      tx_src.delete();
      txreq_cnt   = 0;
      dut_low_cnt = 0;
   endtask

   task automatic m_start();
      m_low = 1'b0; scl = 1'b1; wq();
      m_low = 1'b1; wq();
      scl = 1'b0; wq();
   endtask

   task automatic m_rstart();
      m_low = 1'b0; wq();
      scl = 1'b1; wq();
      m_low = 1'b1; wq();
      scl = 1'b0; wq();
   endtask

   task automatic m_stop();
      m_low = 1'b1; wq();
      scl = 1'b1; wq();
      m_low = 1'b0; wq(); wq();
   endtask

   task automatic m_bit(input logic b, output logic s);
      m_low = ~b; wq();
      scl = 1'b1; wq();
      s = sda;
      if (glitch_arm && b) begin
         m_low = 1'b1; repeat (2) @(negedge clk);
         m_low = 1'b0; glitch_arm = 1'b0;
      end
      wq();
      scl = 1'b0; wq();
   endtask

   task automatic m_send(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(b[i], s);
      m_bit(1'b1, ack);
   endtask

   task automatic m_read(input logic nack, output logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, s);
         v[i] = s;
      end
      m_bit(nack, s);
   endtask

   task automatic test_reset();
      rst = 1'b0; repeat (4) @(negedge clk);
      vectors++;
      if ({rx_valid, tx_req, busy, rw_dir, nack_seen} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {rx_valid, tx_req, busy, rw_dir, nack_seen});
      end
      vectors++;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      vectors++;
      if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
      rst = 1'b1; repeat (4) @(negedge clk);
   endtask

   task automatic test_write();
      logic a0, a1, a2, busy_mid, rw_mid;
      clear_mon();
      m_start();
      m_send(8'h4E, a0); m_send(8'h81, a1); m_send(8'h02, a2);
      busy_mid = busy; rw_mid = rw_dir;
      m_stop();
      vectors++;
      if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks got %b want 000", {a0, a1, a2}); end
      vectors++;
      if (rx_log.size() != 2 || rx_log[0] !== 8'h81 || rx_log[1] !== 8'h02) begin
         errors++; $display("FAIL write_rx got %0d bytes want 81,02", rx_log.size());
      end
      vectors++;
      if ({busy_mid, rw_mid} !== 2'b10) begin errors++; $display("FAIL write_busy_rw got %b want 10", {busy_mid, rw_mid}); end
      vectors++;
      if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
   endtask

   task automatic test_mismatch();
      logic a0, a1, a2, busy_mid;
      clear_mon();
      m_start(); m_send(8'h7E, a0); m_send(8'h55, a1); busy_mid = busy; m_stop();
      m_start(); m_send(8'h00, a2); m_stop();
      vectors++;
      if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL mismatch_acks got %b want 111", {a0, a1, a2}); end
      vectors++;
      if (dut_low_cnt != 0 || rx_log.size() != 0) begin
         errors++; $display("FAIL mismatch_quiet got low=%0d rx=%0d want 0,0", dut_low_cnt, rx_log.size());
      end
      vectors++;
      if (busy_mid !== 1'b0) begin errors++; $display("FAIL mismatch_busy got %b want 0", busy_mid); end
   endtask

   task automatic test_read();
      logic a0, nack_mid;
      logic [7:0] v0, v1;
      clear_mon();
      tx_src.push_back(8'hA5); tx_src.push_back(8'h3C);
      m_start(); m_send(8'h4F, a0);
      m_read(1'b0, v0); m_read(1'b1, v1);
      nack_mid = nack_seen;
      m_stop();
      vectors++;
      if (a0 !== 1'b0) begin errors++; $display("FAIL read_addr_ack got %b want 0", a0); end
      vectors++;
      if ({v0, v1} !== 16'hA53C) begin errors++; $display("FAIL read_data got %h want a53c", {v0, v1}); end
      vectors++;
      if (txreq_cnt != 2) begin errors++; $display("FAIL read_txreq got %0d want 2", txreq_cnt); end
      vectors++;
      if ({nack_mid, rw_dir, busy, nack_seen} !== 4'b1101) begin
         errors++; $display("FAIL read_flags got %b want 1101", {nack_mid, rw_dir, busy, nack_seen});
      end
   endtask

   task automatic test_rstart();
      logic a0, a1, a2, nack_mid;
      logic [7:0] v, exp_v;
      clear_mon();
      exp_v = 8'($urandom);
      m_start(); nack_mid = nack_seen;
      m_send(8'h4E, a0); m_send(8'h11, a1);
      tx_src.push_back(exp_v);
      m_rstart(); m_send(8'h4F, a2); m_read(1'b1, v);
      vectors++;
      if ({a0, a1, a2, nack_mid} !== 4'b0000) begin
         errors++; $display("FAIL rstart_acks got %b want 0000", {a0, a1, a2, nack_mid});
      end
      vectors++;
      if (rx_log.size() != 1 || rx_log[0] !== 8'h11) begin errors++; $display("FAIL rstart_rx got %0d bytes want 11", rx_log.size()); end
      vectors++;
      if (rw_dir !== 1'b1 || txreq_cnt != 1 || v !== exp_v) begin
         errors++; $display("FAIL rstart_read got rw=%b req=%0d v=%h want 1,1,%h", rw_dir, txreq_cnt, v, exp_v);
      end
      m_stop();
   endtask

   task automatic test_rx_full();
      logic a0, a1, a2;
      logic [7:0] d1, d2;
      clear_mon();
      d1 = 8'($urandom); d2 = 8'($urandom);
      m_start(); m_send(8'h4E, a0);
      rx_full = 1'b0; m_send(d1, a1);
      rx_full = 1'b1; m_send(d2, a2);
      rx_full = 1'b0; m_stop();
      vectors++;
      if ({a0, a1, a2} !== 3'b001) begin errors++; $display("FAIL rxfull_acks got %b want 001", {a0, a1, a2}); end
      vectors++;
      if (rx_log.size() != 1 || rx_log[0] !== d1) begin errors++; $display("FAIL rxfull_rx got %0d bytes want 1 (%h)", rx_log.size(), d1); end
   endtask

   task automatic test_stop_midbyte();
      logic a0, s;
      clear_mon();
      m_start(); m_send(8'h4E, a0);
      for (int i = 0; i < 4; i++) m_bit(1'($urandom), s);
      m_stop();
      vectors++;
      if (rx_log.size() != 0 || busy !== 1'b0 || a0 !== 1'b0) begin
         errors++; $display("FAIL stop_midbyte got rx=%0d busy=%b ack=%b want 0,0,0", rx_log.size(), busy, a0);
      end
   endtask

   task automatic test_reset_mid();
      logic s, a0;
      logic [7:0] addr;
      clear_mon();
      addr = 8'h4E;
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(addr[i], s);
      m_low = 1'b0;
      repeat (q / 2) @(negedge clk);
      vectors++;
      if (sda !== 1'b0) begin errors++; $display("FAIL resetmid_ack_driven got %b want 0", sda); end
      rst = 1'b0; @(negedge clk);
      vectors++;
      if (sda !== 1'b1 || {busy, rw_dir, nack_seen, rx_valid, tx_req} !== 5'b0) begin
         errors++; $display("FAIL resetmid_release got sda=%b flags=%b want 1,00000", sda, {busy, rw_dir, nack_seen, rx_valid, tx_req});
      end
      rst = 1'b1; scl = 1'b1; wq(); wq();
      m_start(); m_send(8'h4E, a0); m_stop();
      vectors++;
      if (a0 !== 1'b0) begin errors++; $display("FAIL resetmid_recover got ack=%b want 0", a0); end
   endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   task automatic test_glitch();
      logic a0, a1, busy_mid;
      clear_mon();
      m_start(); m_send(8'h4E, a0);
      glitch_arm = 1'b1;
      m_send(8'hB7, a1); busy_mid = busy;
      m_stop();
      vectors++;
      if ({a0, a1, busy_mid} !== 3'b001 || rx_log.size() != 1 || rx_log[0] !== 8'hB7) begin
         errors++; $display("FAIL glitch got acks=%b busy=%b rx=%0d want 00,1,1xB7", {a0, a1}, busy_mid, rx_log.size());
      end
   endtask
`endif

   // Reference: ACK iff addressed (and not full); strobes only accepted write bytes; reads return the supplied bytes.
   task automatic test_random();
      for (int t = 0; t < 12; t++) begin
         logic [6:0] addr;
         logic       rw, matched, aack, ack, bad;
         int         n;
         logic [7:0] data[3];
         logic       full[3];
         logic [7:0] exp_rx[$];
         logic [7:0] v;
         clear_mon();
         q = 8 + int'($urandom_range(6));
         if ($urandom_range(1) == 1) addr = 7'h27;
         else begin
            addr = 7'($urandom);
            if (addr == 7'h27) addr = 7'h00;
         end
         rw = 1'($urandom);
         n = 1 + int'($urandom_range(2));
         matched = (addr == 7'h27);
         for (int i = 0; i < 3; i++) begin
            data[i] = 8'($urandom);
            full[i] = ($urandom_range(3) == 0);
         end
         if (rw && matched) for (int i = 0; i < n; i++) tx_src.push_back(data[i]);
         m_start();
         m_send({addr, rw}, aack);
         vectors++;
         if (aack !== !matched) begin errors++; $display("FAIL rand_addr_ack txn %0d got %b want %b", t, aack, !matched); end
         for (int i = 0; i < n; i++) begin
            if (!rw) begin
               rx_full = full[i];
               m_send(data[i], ack);
               rx_full = 1'b0;
               if (matched && !full[i]) exp_rx.push_back(data[i]);
               vectors++;
               if (ack !== !(matched && !full[i])) begin
                  errors++; $display("FAIL rand_data_ack txn %0d byte %0d got %b want %b", t, i, ack, !(matched && !full[i]));
               end
            end else begin
               m_read(i == n - 1, v);
               vectors++;
               if (v !== (matched ? data[i] : 8'hFF)) begin
                  errors++; $display("FAIL rand_read txn %0d byte %0d got %h want %h", t, i, v, matched ? data[i] : 8'hFF);
               end
            end
         end
         m_stop();
         bad = (rx_log.size() != exp_rx.size());
         if (!bad) foreach (exp_rx[k]) if (rx_log[k] !== exp_rx[k]) bad = 1'b1;
         vectors++;
         if (bad) begin errors++; $display("FAIL rand_rx txn %0d got %0d bytes want %0d", t, rx_log.size(), exp_rx.size()); end
         vectors++;
         if (txreq_cnt != ((matched && rw) ? n : 0) || nack_seen !== (matched && rw) || busy !== 1'b0) begin
            errors++; $display("FAIL rand_status txn %0d got req=%0d nack=%b busy=%b want %0d,%b,0",
                               t, txreq_cnt, nack_seen, busy, (matched && rw) ? n : 0, matched && rw);
         end
         if (!matched) begin
            vectors++;
            if (dut_low_cnt != 0) begin errors++; $display("FAIL rand_quiet txn %0d got %0d low clks want 0", t, dut_low_cnt); end
         end
      end
      q = 10;
   endtask

   initial begin
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_rstart();
      test_rx_full();
      test_stop_midbyte();
      test_reset_mid();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      test_glitch();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
